// File: rtl/csa_in_packer_if.sv
// csa_in_packer_if: AXI-Stream slave and csa_in FIFO write-port bundle.
// The slave modport is the packer side. It receives the stream and full flag,
// and drives tready, wen and wdata. The master modport is the opposite side.
interface csa_in_packer_if #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int CSA_CALC_IN_WIDTH = 40
);
  logic s00_axis_tvalid;
  logic s00_axis_tready;
  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata;
  logic s00_axis_tlast;
  logic csa_in_wfull;
  logic csa_in_wen;
  logic [CSA_CALC_IN_WIDTH-1:0] csa_in_wdata;
  modport slave (
    input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast, csa_in_wfull,
    output s00_axis_tready, csa_in_wen, csa_in_wdata
  );
  modport master (
    output s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast, csa_in_wfull,
    input  s00_axis_tready, csa_in_wen, csa_in_wdata
  );
endinterface

// File: rtl/csa_in_packer.sv
// csa_in_packer: packs 32-bit stream words into 160-bit groups and emits them as 40-bit csa_in FIFO records.
// Ports: axi_mm_clk and rst_n (synchronous, active-low).
//   s00 carries the stream slave and the FIFO write port.
//   s00_axis_tready_count counts accepted words.
//   s00_axis_tvalid_count counts cycles with tvalid high.
//   csa_in_wen_count counts records written.
//   buffer_data is the live packing buffer.
module csa_in_packer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int CSA_CALC_IN_WIDTH = 40,
  parameter int GROUP_WORDS = 5,
  parameter int GROUP_RECORDS = 4
) (
  input  logic axi_mm_clk,
  input  logic rst_n,
  csa_in_packer_if.slave s00,
  output logic [31:0] s00_axis_tready_count,
  output logic [31:0] s00_axis_tvalid_count,
  output logic [31:0] csa_in_wen_count,
  output logic [GROUP_WORDS*AXIS_DATA_WIDTH-1:0] buffer_data
);
  localparam int BW = GROUP_WORDS * AXIS_DATA_WIDTH;
  typedef enum logic {COLLECT, EMIT} state_t;
  state_t state;
  logic [2:0] word_idx, rec_total;
  logic [1:0] rec_idx;
  logic acc, last_rec, close_grp;
  assign acc = s00.s00_axis_tvalid & s00.s00_axis_tready;
  assign close_grp = word_idx == 3'(GROUP_WORDS - 1) || s00.s00_axis_tlast;
  assign last_rec = {1'b0, rec_idx} == rec_total - 3'd1;
  assign s00.csa_in_wen = state == EMIT && !s00.csa_in_wfull;
  // Record slice stays driven through a FIFO stall; zero outside EMIT.
  assign s00.csa_in_wdata = state == EMIT ?
    CSA_CALC_IN_WIDTH'(buffer_data >> (CSA_CALC_IN_WIDTH * rec_idx)) : '0;
  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n) begin
      state <= COLLECT;
      s00.s00_axis_tready <= 1'b0;
      buffer_data <= '0;
      word_idx <= '0;
      rec_idx <= '0;
      rec_total <= '0;
      s00_axis_tready_count <= '0;
      s00_axis_tvalid_count <= '0;
      csa_in_wen_count <= '0;
    end else begin
      if (s00.s00_axis_tvalid) s00_axis_tvalid_count <= s00_axis_tvalid_count + 32'd1;
      if (acc) s00_axis_tready_count <= s00_axis_tready_count + 32'd1;
      if (s00.csa_in_wen) csa_in_wen_count <= csa_in_wen_count + 32'd1;
      if (state == COLLECT) begin
        s00.s00_axis_tready <= 1'b1;
        if (acc) begin
          // Buffer is all-zero at group start, so OR-ing each word into its slot is enough.
          buffer_data <= buffer_data | (BW'(s00.s00_axis_tdata) << (AXIS_DATA_WIDTH * word_idx));
          word_idx <= word_idx + 3'd1;
          if (close_grp) begin
            s00.s00_axis_tready <= 1'b0;
            // A partial group of w words (4w bytes) fits exactly in w records.
            rec_total <= word_idx == 3'(GROUP_WORDS - 1) ? 3'(GROUP_RECORDS) : word_idx + 3'd1;
            rec_idx <= '0;
            state <= EMIT;
          end
        end
      end else if (s00.csa_in_wen) begin
        if (last_rec) begin
          buffer_data <= '0;
          word_idx <= '0;
          s00.s00_axis_tready <= 1'b1;
          state <= COLLECT;
        end else begin
          rec_idx <= rec_idx + 2'd1;
        end
      end
    end
  end
endmodule
